// File: rtl/ddp_pkg.sv
// Shared DDP packet-path definitions: beat layout and packet FIFO read-side states.
package ddp_pkg;

  localparam int DDP_PKT_W    = 265;
  localparam int DDP_EOP_BIT  = 264;
  localparam int DDP_CTRL_MSB = 263;
  localparam int DDP_CTRL_LSB = 256;
  localparam int DDP_DATA_W   = 256;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_IN_PKT = 2'd1,
    RD_JAM    = 2'd2
  } rd_state_e;

endpackage

// File: rtl/ddp_pkt_fifo_ram.sv
// Simple dual-port beat storage: synchronous write, asynchronous read.
// Contents are not reset; occupancy is tracked by the FIFO controller.
module ddp_pkt_fifo_ram
  import ddp_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int W     = DDP_PKT_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ddp_pkt_fifo.sv
// Store-and-forward (or cut-through) FWFT packet FIFO between DDP assembly and segmentation.
// Head beat is registered; a complete packet becomes readable the cycle after its EOP is pushed.
module ddp_pkt_fifo
  import ddp_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int STORE_FWD = 1,
  parameter int AFULL_LVL = 56,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ddpPktPush,
  input  logic [DDP_PKT_W-1:0] ddpPktDataIn,
  output logic                 ddpPktFull,
  output logic                 ddpPktAfull,
  input  logic                 ddpPktPop,
  output logic [DDP_PKT_W-1:0] ddpPktDataOut,
  output logic                 ddpPktEmpty,
  output logic [CW-1:0]        pktCount,
  output logic [CW-1:0]        usedCount,
  output logic                 ovfErr,
  output logic                 udfErr
);

  logic [AW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]        used_q, used_d, pkt_q, pkt_d;
  logic [DDP_PKT_W-1:0] dout_q, dout_d, ram_rdata;
  logic                 ovf_q, udf_q;
  rd_state_e            state_q;
  logic                 full, empty, push_acc, pop_acc, push_eop, pop_eop;

  assign full  = (used_q == CW'(DEPTH));
  // Outside a packet, store-and-forward hides beats until at least one EOP is stored.
  assign empty = (used_q == '0) |
                 ((STORE_FWD != 0) & (pkt_q == '0) & (state_q == RD_IDLE));

  assign push_acc = ddpPktPush & ~full;
  assign pop_acc  = ddpPktPop & ~empty;
  assign push_eop = push_acc & ddpPktDataIn[DDP_EOP_BIT];
  assign pop_eop  = pop_acc & dout_q[DDP_EOP_BIT];

  ddp_pkt_fifo_ram #(
    .DEPTH (DEPTH),
    .W     (DDP_PKT_W)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (push_acc),
    .waddr_i (wptr_q),
    .wdata_i (ddpPktDataIn),
    .raddr_i (rptr_d),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    wptr_d = push_acc ? wptr_q + AW'(1) : wptr_q;
    rptr_d = pop_acc  ? rptr_q + AW'(1) : rptr_q;

    used_d = used_q;
    if (push_acc && !pop_acc)      used_d = used_q + CW'(1);
    else if (pop_acc && !push_acc) used_d = used_q - CW'(1);

    pkt_d = pkt_q;
    if (push_eop && !pop_eop && pkt_q != CW'(DEPTH)) pkt_d = pkt_q + CW'(1);
    else if (pop_eop && !push_eop && pkt_q != '0)    pkt_d = pkt_q - CW'(1);

    // A beat written into the slot that becomes the head must bypass the RAM.
    dout_d = dout_q;
    if (used_d != '0) begin
      dout_d = (push_acc && (wptr_q == rptr_d)) ? ddpPktDataIn : ram_rdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      used_q <= '0;
      pkt_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      used_q <= used_d;
      pkt_q  <= pkt_d;
      dout_q <= dout_d;
      ovf_q  <= ovf_q | (ddpPktPush & full);
      udf_q  <= udf_q | (ddpPktPop & empty);
    end
  end

  // Jam covers a packet longer than the FIFO: read side cuts through until its EOP leaves.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RD_IDLE;
    end else if (used_d == CW'(DEPTH) && pkt_d == '0) begin
      state_q <= RD_JAM;
    end else if (pop_acc) begin
      if (pop_eop)                   state_q <= RD_IDLE;
      else if (state_q == RD_IDLE)   state_q <= RD_IN_PKT;
    end
  end

  assign ddpPktFull    = full;
  assign ddpPktAfull   = (used_q >= CW'(AFULL_LVL));
  assign ddpPktEmpty   = empty;
  assign ddpPktDataOut = dout_q;
  assign pktCount      = pkt_q;
  assign usedCount     = used_q;
  assign ovfErr        = ovf_q;
  assign udfErr        = udf_q;

endmodule
